// File: rtl/shift_pkg.sv
// Shared definitions for the round-robin shift arbiter: operation codes,
// controller states and the default operand width.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shift arbiter and
// the result consumer.
interface shift_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int SHW   = $clog2(WIDTH),
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*SHW-1:0]   req_amt;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_carry;

  modport master (
    output req_valid, req_a, req_amt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_amt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
  );
endinterface

// File: rtl/shift_engine.sv
// One-bit-per-cycle shifter: loads an operand, then each step shifts once,
// records the bit that left and counts the remaining shift amount down.
module shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] load_a,
  input  logic [SHW-1:0]   load_amt,
  input  shift_op_e        load_op,
  output logic [WIDTH-1:0] data,
  output logic             carry,
  output logic             last
);

  logic [SHW-1:0]   count;
  shift_op_e        op;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;

  always_comb begin
    shifted = data;
    out_bit = 1'b0;
    case (op)
      OP_SLL: begin shifted = {data[WIDTH-2:0], 1'b0};         out_bit = data[WIDTH-1]; end
      OP_SRL: begin shifted = {1'b0, data[WIDTH-1:1]};         out_bit = data[0];       end
      OP_SRA: begin shifted = {data[WIDTH-1], data[WIDTH-1:1]}; out_bit = data[0];       end
      OP_ROL: begin shifted = {data[WIDTH-2:0], data[WIDTH-1]}; out_bit = data[WIDTH-1]; end
      default: ;
    endcase
  end

  // Carry starts at 0 on load so a zero-amount operation reports no bit out.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      carry <= 1'b0;
      count <= '0;
      op    <= OP_SLL;
    end else if (load) begin
      data  <= load_a;
      carry <= 1'b0;
      count <= load_amt;
      op    <= load_op;
    end else if (step) begin
      data  <= shifted;
      carry <= out_bit;
      count <= count - 1'b1;
    end
  end

  assign last = (count == SHW'(1));

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared
// serial shift engine, holding each result until the consumer takes it.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  shift_arbiter_if.slave  bus,
  output logic            busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state, next_state;
  logic [IDW-1:0]   ptr, next_ptr;
  logic [IDW-1:0]   grant_idx;
  logic             found;
  int unsigned      idx;
  logic             load, step, last;
  logic [WIDTH-1:0] sel_a;
  logic [SHW-1:0]   sel_amt;
  shift_op_e        sel_op;

  // Rotating priority search starting at ptr; the first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign sel_a   = bus.req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_amt = bus.req_amt[grant_idx*SHW +: SHW];
  assign sel_op  = shift_op_e'(bus.req_op[grant_idx*2 +: 2]);

  always_comb begin
    next_state    = state;
    next_ptr      = ptr;
    load          = 1'b0;
    step          = 1'b0;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          bus.req_ready[grant_idx] = 1'b1;
          load       = 1'b1;
          next_state = (sel_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          next_state = IDLE;
          next_ptr   = (bus.rsp_id == IDW'(NREQ - 1)) ? '0 : bus.rsp_id + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      bus.rsp_id <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      if (load) bus.rsp_id <= grant_idx;
    end
  end

  shift_engine #(.WIDTH(WIDTH), .SHW(SHW)) u_engine (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .load_a   (sel_a),
    .load_amt (sel_amt),
    .load_op  (sel_op),
    .data     (bus.rsp_data),
    .carry    (bus.rsp_carry),
    .last     (last)
  );

  assign bus.rsp_valid = (state == DONE);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with WIDTH=8, NREQ=4.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  shift_arbiter_if #(.WIDTH(8), .NREQ(4), .SHW(3)) bus ();

  shift_arbiter #(.WIDTH(8), .NREQ(4), .SHW(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [2:0] amt,
                               input logic [1:0] op);
    bus.req_a[id*8 +: 8]   = a;
    bus.req_amt[id*3 +: 3] = amt;
    bus.req_op[id*2 +: 2]  = op;
    bus.req_valid[id]      = 1'b1;
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid after an accept edge; returns edges counted from accept.
  task automatic waitResponse(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  // Issues one request to the current winner and checks the full transaction.
  task automatic runRequest(input int id, input logic [7:0] a, input logic [2:0] amt,
                            input logic [1:0] op, input logic [7:0] expData, input logic expCarry);
    int lat;
    applyStimulus(id, a, amt, op);
    #1 checkOutput("grant", 32'(bus.req_ready), 32'(4'b0001 << id));
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    waitResponse(lat);
    checkOutput("latency", lat, amt + 1);
    checkOutput("rsp_data", 32'(bus.rsp_data), 32'(expData));
    checkOutput("rsp_carry", 32'(bus.rsp_carry), 32'(expCarry));
    checkOutput("rsp_id", 32'(bus.rsp_id), id);
    checkOutput("busy_done", 32'(busy), 1);
    @(posedge clk);
    #1 checkOutput("idle_after_rsp", {busy, bus.rsp_valid}, 0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0] holdData;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_amt   = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    applyReset(2);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 0);
    checkOutput("reset_rsp_data", 32'(bus.rsp_data), 0);
    checkOutput("reset_rsp_carry", 32'(bus.rsp_carry), 0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 0);

    runRequest(0, 8'b10010100, 3'd3, 2'b00, 8'b10100000, 1'b0);
    runRequest(1, 8'b11110011, 3'd2, 2'b10, 8'b11111100, 1'b1);
    runRequest(2, 8'b10010110, 3'd0, 2'b11, 8'b10010110, 1'b0);

    // All four requesters held valid: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) applyStimulus(i, 8'h01, 3'd1, 2'b00);
    applyReset(2);
    for (int k = 0; k < 5; k++) begin
      lat = 0;
      while (bus.req_ready == 4'b0000 && lat < 10) begin
        @(posedge clk);
        #1 lat++;
      end
      checkOutput("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      @(posedge clk);
      #1 waitResponse(lat);
      checkOutput("rr_rsp_id", 32'(bus.rsp_id), k % 4);
      checkOutput("rr_rsp_data", 32'(bus.rsp_data), 32'h02);
    end
    bus.req_valid = '0;

    // Consumer stalls for five cycles while another request waits.
    applyReset(1);
    bus.rsp_ready = 1'b0;
    applyStimulus(1, 8'hA5, 3'd2, 2'b01);
    #1 checkOutput("stall_grant", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    applyStimulus(0, 8'h81, 3'd1, 2'b11);
    checkOutput("shift_req_ready", 32'(bus.req_ready), 0);
    waitResponse(lat);
    checkOutput("stall_latency", lat, 3);
    holdData = 8'h29;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 1);
      checkOutput("stall_rsp_data", 32'(bus.rsp_data), 32'(holdData));
      checkOutput("stall_rsp_id", 32'(bus.rsp_id), 1);
      checkOutput("stall_rsp_carry", 32'(bus.rsp_carry), 0);
      checkOutput("stall_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput("resume_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    waitResponse(lat);
    checkOutput("rol_latency", lat, 2);
    checkOutput("rol_rsp_data", 32'(bus.rsp_data), 32'h03);
    checkOutput("rol_rsp_carry", 32'(bus.rsp_carry), 1);
    checkOutput("rol_rsp_id", 32'(bus.rsp_id), 0);
    @(posedge clk);

    // Reset while a long shift is in flight drops it and clears the pointer.
    #1 applyStimulus(2, 8'hFF, 3'd7, 2'b00);
    #1 checkOutput("long_grant", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1 bus.req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("abort_req_ready", 32'(bus.req_ready), 0);
    checkOutput("abort_rsp_data", 32'(bus.rsp_data), 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) seen++;
    end
    checkOutput("abort_no_rsp", seen, 0);
    applyStimulus(0, 8'h11, 3'd1, 2'b00);
    applyStimulus(3, 8'h22, 3'd1, 2'b00);
    #1 checkOutput("abort_ptr_zero", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
